// File: rtl/pcihellocore_button_in.sv
// Avalon-MM input PIO: synchronises and debounces in_port, latches selected
// debounced edges into write-1-to-clear flags and raises a maskable level irq.
module pcihellocore_button_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_EDGECAP = 2'd2,
    ADDR_RSVD    = 2'd3
  } addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] settle, ev, clr;
  logic             wr_en;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign wr_en = chipselect && !write_n;

  // A bit settles once sync has disagreed with db on DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    db_d   = db_q;
    settle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          settle[i] = 1'b1;
          db_d[i]   = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       ev = settle & sync;
      1:       ev = settle & ~sync;
      default: ev = settle;
    endcase
  end

  // A clear coinciding with a new event leaves the flag set.
  assign clr    = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign cap_d  = ev | (cap_q & ~clr);
  assign mask_d = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the counter array is reset too, so a reset mid-debounce discards partial counts.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      db_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its pre-edge input, forming a shift chain.
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      db_q   <= db_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (addr_e'(address))
      ADDR_DATA:    readdata[WIDTH-1:0] = db_q;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_pcihellocore_button_in.sv
// Scoreboarded random bench for pcihellocore_button_in: three instances (rising/8b,
// falling/4b, any/8b) share stimulus and are checked against a sample-window model.
module tb_pcihellocore_button_in;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int NDUT = 3;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [1:0]  address    = '0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [7:0]  in_port    = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  logic [7:0]  cur_in = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pcihellocore_button_in #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

  pcihellocore_button_in #(.WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in_port[3:0]), .irq(irq1));

  pcihellocore_button_in #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

  // Reference model: register state per instance plus the raw in_port samples taken since reset.
  logic [31:0] m_db   [NDUT];
  logic [31:0] m_mask [NDUT];
  logic [31:0] m_cap  [NDUT];
  logic [7:0]  hist   [$];

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [2:0]  irq;
  } exp_t;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(int d);
    return (d == 1) ? 32'h0000_000F : 32'h0000_00FF;
  endfunction

  // Value the debouncer sees j edges back: the in_port sample taken S+j edges earlier.
  function automatic logic [7:0] deb_in(int j);
    int idx = hist.size() - S - j;
    return (idx < 0) ? 8'h00 : hist[idx];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_db[d]   = '0;
      m_mask[d] = '0;
      m_cap[d]  = '0;
    end
    hist.delete();
  endtask

  // One rising edge: a bit flips when the last D debouncer inputs all equal its complement.
  task automatic model_step();
    logic [31:0] all1, all0, flip, ev, clr, smp;
    logic        we;
    we = chipselect && !write_n;
    for (int d = 0; d < NDUT; d++) begin
      all1 = '1;
      all0 = '1;
      for (int j = 0; j < D; j++) begin
        smp  = {24'h0, deb_in(j)};
        all1 = all1 & smp;
        all0 = all0 & ~smp;
      end
      flip = ((~m_db[d] & all1) | (m_db[d] & all0)) & wmask(d);
      case (d)
        0:       ev = flip & ~m_db[d];
        1:       ev = flip & m_db[d];
        default: ev = flip;
      endcase
      clr = (we && address == 2'd2) ? (writedata & wmask(d)) : 32'h0;
      m_cap[d] = ev | (m_cap[d] & ~clr);
      if (we && address == 2'd1) m_mask[d] = writedata & wmask(d);
      m_db[d] = m_db[d] ^ flip;
    end
    hist.push_back(in_port);
    if (hist.size() > S + D) void'(hist.pop_front());
  endtask

  function automatic logic [31:0] model_read(int d, logic [1:0] a);
    case (a)
      2'd0:    return m_db[d];
      2'd1:    return m_mask[d];
      2'd2:    return m_cap[d];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq(int d);
    return |(m_cap[d] & m_mask[d]);
  endfunction

  // Advance one clock, then present a new bus cycle; reads queue their expected response.
  task automatic drive(input logic rst, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = cur_in;
    if (rst) model_reset();
    if (cs && wn) begin
      e.addr = a;
      e.rd0  = model_read(0, a);
      e.rd1  = model_read(1, a);
      e.rd2  = model_read(2, a);
      e.irq  = {model_irq(2), model_irq(1), model_irq(0)};
      exp_q.push_back(e);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    drive(1'b0, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_n(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) rd(a);
  endtask

  // Monitor: every presented read is compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chipselect && write_n) begin
      check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("rdata_a%0d_rise8", e.addr), rd0, e.rd0);
        check($sformatf("rdata_a%0d_fall4", e.addr), rd1, e.rd1);
        check($sformatf("rdata_a%0d_any8", e.addr),  rd2, e.rd2);
        check("irq_rise8", {31'h0, irq0}, {31'h0, e.irq[0]});
        check("irq_fall4", {31'h0, irq1}, {31'h0, e.irq[1]});
        check("irq_any8",  {31'h0, irq2}, {31'h0, e.irq[2]});
      end
    end
  end

  initial begin
    bit noisy;
    model_reset();

    // Reset values at every address, then a reset landing mid-debounce with in_port high.
    for (int a = 0; a < 4; a++) drive(1'b1, 1'b1, 1'b1, 2'(a), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    cur_in = 8'hFF;
    rd_n(2'd0, 4);
    for (int a = 0; a < 4; a++) drive(1'b1, 1'b1, 1'b1, 2'(a), 32'h0);
    rd_n(2'd0, 8);
    rd(2'd2);
    wr(2'd2, 32'hFFFF_FFFF);
    cur_in = 8'h00;
    rd_n(2'd0, 8);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);

    // Glitches of 1..5 cycles on bit 0, then a long hold.
    for (int len = 1; len <= 5; len++) begin
      cur_in = 8'h01;
      rd_n(2'd0, len);
      cur_in = 8'h00;
      rd_n(2'd0, 8);
      rd(2'd2);
    end
    wr(2'd2, 32'hFFFF_FFFF);
    cur_in = 8'h01;
    rd_n(2'd0, 10);
    rd(2'd2);

    // Masking: bit 1 captures while masked off, then the mask enables it.
    wr(2'd1, 32'h0000_0001);
    cur_in = 8'h03;
    rd_n(2'd2, 8);
    wr(2'd1, 32'h0000_0003);
    rd(2'd2);
    rd(2'd1);

    // Write-1-to-clear of one bit; writes to DATA, reserved and unselected writes ignored.
    cur_in = 8'h07;
    rd_n(2'd2, 8);
    wr(2'd2, 32'h0000_0004);
    rd(2'd2);
    wr(2'd0, 32'h0000_00FF);
    wr(2'd3, 32'h0000_00FF);
    drive(1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0000);
    for (int a = 0; a < 4; a++) rd(2'(a));

    // Clear of bit 0 lands on the same edge as its new debounced rise.
    cur_in = 8'h06;
    rd_n(2'd0, 8);
    wr(2'd2, 32'h0000_0002);
    rd(2'd2);
    cur_in = 8'h07;
    rd_n(2'd2, 5);
    wr(2'd2, 32'h0000_0001);
    rd(2'd2);
    rd(2'd0);

    // Randomised traffic with slow and bouncy input phases and occasional resets.
    noisy = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int op;
      if ($urandom_range(0, 63) == 0) noisy = !noisy;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, noisy ? 2 : 15) == 0) cur_in[b] = !cur_in[b];
      op = int'($urandom_range(0, 199));
      if (op < 120)      rd(2'($urandom_range(0, 3)));
      else if (op < 150) wr(2'd2, $urandom);
      else if (op < 170) wr(2'd1, $urandom);
      else if (op < 180) wr(2'($urandom_range(0, 3)), $urandom);
      else if (op < 198) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      else               drive(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 32'h0);
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcihellocore_button_in.md
# pcihellocore_button_in

Avalon-MM slave input port for the pcihellocore system. It is the read-direction counterpart of the LED output PIOs: it samples external switches and pushbuttons on `in_port`, synchronises and debounces them, latches selected edges, and raises a maskable interrupt. The host reads the debounced value and edge flags over the PCI-to-Avalon bridge and clears the flags.

## Interface
Parameters:
- `WIDTH`, 8: number of input bits, 1..32. `readdata` bits above `WIDTH` read 0.
- `SYNC_STAGES`, 2: synchroniser depth, 2..4.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a change, 1..65535.
- `EDGE_TYPE`, 0: edge captured. 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk` in 1: system clock. This is the block's only clock.
- `reset` in 1: reset. Asynchronous and active-high.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data. Read latency is 0 (combinational from registers).
- `in_port` in `WIDTH`: asynchronous external inputs.
- `irq` out 1: level interrupt.

## Operation
- Register map:
  - 0 = DATA: debounced value, read-only.
  - 1 = IRQMASK: R/W, `WIDTH` bits.
  - 2 = EDGECAP: read, and write-1-to-clear per bit.
  - 3 = reserved: reads 0, writes ignored.
- A write occurs when `chipselect && !write_n`. Writes to address 0 are ignored.
- Synchroniser: `SYNC_STAGES` flops per bit, reset 0. Output is `sync[i]`.
- Debounce, per bit: a stable register `db[i]` (reset 0) and a counter `cnt[i]` (reset 0, width `clog2(DEBOUNCE_CYCLES+1)`).
  - If `sync[i]==db[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i]==DEBOUNCE_CYCLES-1`: `db[i]` <= `sync[i]` and `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync` never reaches `db`, and the counter restarts from 0.
- Edge event `ev[i]` is asserted in the cycle where `db[i]` is about to change in the selected direction. Rising means 0->1, falling means 1->0, any means either.
- EDGECAP per bit: `cap[i]` <= `ev[i] | (cap[i] & !clr[i])`, where `clr[i]` = write to address 2 with `writedata[i]`=1.
  - A simultaneous edge and clear leaves the bit set; the event is never lost.
- `irq` = `|(cap & mask)`. It is combinational from registers, so it asserts in the same cycle the capture bit or mask bit becomes 1.
- `readdata` = zero-extended mux of {`db`, `mask`, `cap`, 0} by `address`. It is driven regardless of `chipselect`, and the bus uses it only when selected. Reads have no side effects.

## Timing
- Reset values:
  - All synchroniser flops, `db`, `cnt`, `mask` and `cap` are 0.
  - `irq` = 0.
  - `readdata` = 0 for every address.
- Latency: a clean `in_port` change present before edge k is visible in DATA, and sets EDGECAP, after edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1. With defaults, the change is visible 6 edges after it is first sampled.
- A register write takes effect at the rising edge where the write is presented. A read in the following cycle returns the new value.
- A mask write that enables an already-set capture bit asserts `irq` in the cycle after the write edge.
- `irq` deasserts in the cycle after the clear edge, unless another enabled bit is set or a new edge arrives on the same edge as the clear.
- Reset mid-operation clears all state immediately, including partial debounce counts.
  - An input held at 1 through reset is re-accepted as a 0->1 change after reset release plus the latency above, and it sets EDGECAP when `EDGE_TYPE` is 0 or 2. This is intended behaviour.
- The counter cannot wrap: it never exceeds `DEBOUNCE_CYCLES-1`.

## Test plan
Default parameters unless noted.

1. **Reset values.** Assert `reset` mid-count with `in_port`=8'hFF. Expect `readdata`=0 at addresses 0..3 and `irq`=0 during reset. After release, DATA=8'hFF exactly 6 edges later and EDGECAP=8'hFF.
2. **Glitch rejection and debounce timing.** Pulse `in_port[0]`=1 for 3 cycles. Expect DATA stays 0 and EDGECAP stays 0. Then hold it for 10 cycles. Expect DATA=8'h01 on the 6th edge after the first sample, and never earlier.
3. **Interrupt masking.** Write IRQMASK=8'h01, then toggle `in_port[1]` 0->1. Expect EDGECAP=8'h02 and `irq`=0. Write IRQMASK=8'h03. Expect `irq`=1 in the next cycle.
4. **Write-1-to-clear.** With EDGECAP=8'h06, write address 2 with data 8'h04. Expect EDGECAP=8'h02. Write address 0 and address 3 with 8'hFF. Expect DATA, IRQMASK and EDGECAP unchanged.
5. **Simultaneous edge and clear.** Time a write-1-to-clear of bit 0 onto the same edge as a new debounced rise on bit 0. Expect EDGECAP[0]=1 afterwards and `irq` to stay asserted.
6. **Edge-type parameters.** With `EDGE_TYPE`=1, a 1->0 input sets the bit and a 0->1 input does not. With `EDGE_TYPE`=2, both directions set it. With `WIDTH`=4, the upper 28 bits of `readdata` read 0.
